fp_alu_seq: RTL and testbench
=============================

FP_ALU_SEQ -- requirements
Module: fp_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (IEEE-754 single).
REQ-002 SHALL have parameter DEPTH, default 8, number of stored operand vectors (power of two, >=2).
REQ-003 SHALL have parameter ALU_LAT, default 3, cycles from operand change to valid alu_s (>=1).
REQ-004 SHALL have ports:
- clk  in  1  single clock; all logic rising-edge.
- rstn  in  1  synchronous, active-high reset (1 = reset, sampled on clk).
- ld_en  in  1  write one vector into the store.
- ld_addr  in  $clog2(DEPTH)  vector index.
- ld_a  in  WIDTH  first operand.
- ld_b  in  WIDTH  second operand.
- ld_op  in  2  ALU op code for this vector.
- count  in  $clog2(DEPTH)+1  number of vectors to run, 0..DEPTH.
- start  in  1  begin a run.
- loop  in  1  restart at vector 0 after the last vector instead of finishing.
- abort  in  1  stop the run.
- alu_num1  out  WIDTH  operand to fp_alu num1.
- alu_num2  out  WIDTH  operand to fp_alu num2.
- alu_op  out  2  op to fp_alu op.
- alu_s  in  WIDTH  fp_alu result S.
- busy  out  1  run in progress.
- res_valid  out  1  one-cycle strobe; result/res_idx valid.
- res_idx  out  $clog2(DEPTH)  vector index of result.
- result  out  WIDTH  captured alu_s.
- done  out  1  one-cycle strobe at end of a non-looping run.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, CAPTURE, FINISH.
REQ-006 IDLE: start=1 and count>0 -> ISSUE, with idx=0, count latched and busy=1 from the next cycle; start=1 and count=0 -> FINISH.
REQ-007 ISSUE (1 cycle): alu_num1/alu_num2/alu_op register store[idx]; they hold stable until the next ISSUE; -> WAIT with wait counter=0.
REQ-008 WAIT: counter increments each cycle; -> CAPTURE when counter reaches ALU_LAT-1, so alu_s is sampled exactly ALU_LAT cycles after the operand outputs change.
REQ-009 CAPTURE (1 cycle): result<=alu_s, res_idx<=idx, res_valid=1 the following cycle for exactly one cycle.
REQ-010 CAPTURE: idx<count_latched-1 -> idx+1, ISSUE; last vector with loop=0 -> FINISH; last vector with loop=1 -> idx=0, ISSUE (loop sampled in CAPTURE).
REQ-011 FINISH (1 cycle): done=1, busy=0 next cycle, -> IDLE.
REQ-012 Per-vector throughput SHALL be ALU_LAT+2 cycles; no pipelining of vectors.
REQ-013 abort=1 in any non-IDLE state -> IDLE next cycle; no res_valid or done for the interrupted vector; abort beats start, loop and CAPTURE when simultaneous.
REQ-014 start while busy SHALL be ignored; count changes after start SHALL have no effect on the current run.
REQ-015 ld_en SHALL write the store only in IDLE; writes while busy are dropped; the write and a start in the same IDLE cycle SHALL both take effect, with the write visible to the run.
REQ-016 result and res_idx SHALL hold their last values between strobes; alu_* outputs SHALL hold the last vector after the run.

Reset
REQ-017 rstn=1 SHALL force IDLE and zero idx, counters, alu_num1, alu_num2, alu_op, result, res_idx, busy, res_valid and done on the next edge, including mid-run.
REQ-018 The vector store SHALL NOT be cleared by reset.

Structure
REQ-019 A shared package fp_alu_pkg SHALL hold the FSM state enum and the op-code constants (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3).
REQ-020 The store SHALL be a sub-module fp_vec_store: DEPTH x (2*WIDTH+2) register file, one synchronous write port, one asynchronous read port.
REQ-021 fp_alu SHALL stay external; this block connects to it only through the alu_* ports.

Verification (bench stub: alu_s = alu_num1 ^ alu_num2, delayed by ALU_LAT=3 cycles)
REQ-022 Load vec0 = (0x3F8E147B, 0x3F8147AE, op 0), count=1, start -> alu_num1=0x3F8E147B; res_valid once with result=0x000F53D5, res_idx=0; done 1 cycle later.
REQ-023 Load 8 vectors, count=8, loop=0 -> 8 res_valid strobes 5 cycles apart, res_idx 0..7, one done.
REQ-024 count=3, loop=1 for 10 strobes, then loop=0 -> res_idx sequence 0,1,2,0,1,2,...; done only after the final vector 2.
REQ-025 abort during WAIT of vector 1 -> busy=0 next cycle; no further res_valid; no done.
REQ-026 rstn=1 mid-run -> all outputs 0 next cycle; a new start after reset replays the previously loaded vectors unchanged.
REQ-027 count=0 with start -> done after 1 cycle, no res_valid; ld_en while busy -> store contents unchanged.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// Shared types for the floating-point ALU sequencer: FSM state encoding
// and the op codes understood by the external fp_alu.
package fp_alu_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

endpackage

// File: rtl/fp_vec_store.sv
// Operand vector register file: one synchronous write port, one
// combinational read port. Contents deliberately survive reset.
module fp_vec_store #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [2*WIDTH+1:0]       wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [2*WIDTH+1:0]       rdata_o
);

  logic [2*WIDTH+1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fp_alu_seq.sv
// Sequencer that replays stored operand vectors through an external fp_alu,
// one vector at a time, capturing each result after a fixed ALU latency.
module fp_alu_seq
  import fp_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int ALU_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [WIDTH-1:0]         ld_a,
  input  logic [WIDTH-1:0]         ld_b,
  input  logic [1:0]               ld_op,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic                     start,
  input  logic                     loop,
  input  logic                     abort,
  output logic [WIDTH-1:0]         alu_num1,
  output logic [WIDTH-1:0]         alu_num2,
  output logic [1:0]               alu_op,
  input  logic [WIDTH-1:0]         alu_s,
  output logic                     busy,
  output logic                     res_valid,
  output logic [$clog2(DEPTH)-1:0] res_idx,
  output logic [WIDTH-1:0]         result,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int VW = 2 * WIDTH + 2;
  localparam logic [WW-1:0] WAIT_LAST = WW'(ALU_LAT - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [WIDTH-1:0] num1_q, num1_d, num2_q, num2_d, result_q, result_d;
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   res_idx_q, res_idx_d;
  logic            busy_q, busy_d, res_valid_q, res_valid_d, done_q, done_d;
  logic [VW-1:0]   rd_data;
  logic            store_we, last_vec;

  // Loads are accepted only while idle so a running sequence sees a frozen store.
  assign store_we = ld_en && (state_q == S_IDLE);
  assign last_vec = ({1'b0, idx_q} == (cnt_q - 1'b1));

  fp_vec_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_store (
    .clk     (clk),
    .we_i    (store_we),
    .waddr_i (ld_addr),
    .wdata_i ({ld_op, ld_a, ld_b}),
    .raddr_i (idx_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    op_d        = op_q;
    result_d    = result_q;
    res_idx_d   = res_idx_q;
    res_valid_d = 1'b0;
    done_d      = 1'b0;
    // Abort wins over every other action outside IDLE.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (count != '0) begin
              state_d = S_ISSUE;
              idx_d   = '0;
              cnt_d   = count;
            end else begin
              state_d = S_FINISH;
            end
          end
        end
        S_ISSUE: begin
          {op_d, num1_d, num2_d} = rd_data;
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (wcnt_q == WAIT_LAST) begin
            state_d = S_CAPTURE;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          result_d    = alu_s;
          res_idx_d   = idx_q;
          res_valid_d = 1'b1;
          if (!last_vec) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
          end else if (loop) begin
            idx_d   = '0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_FINISH;
          end
        end
        S_FINISH: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      num1_q      <= '0;
      num2_q      <= '0;
      op_q        <= '0;
      result_q    <= '0;
      res_idx_q   <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      op_q        <= op_d;
      result_q    <= result_d;
      res_idx_q   <= res_idx_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
    end
  end

  assign alu_num1  = num1_q;
  assign alu_num2  = num2_q;
  assign alu_op    = op_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign result    = result_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fp_alu_seq.sv
// Directed bench for fp_alu_seq with an XOR stand-in for fp_alu delayed
// by three clocks; a negedge monitor logs strobes for the scenario tasks.
module tb_fp_alu_seq;
  import fp_alu_pkg::*;

  localparam int W = 32;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [W-1:0]  ld_a = '0, ld_b = '0;
  logic [1:0]    ld_op = '0;
  logic [CW-1:0] count = '0;
  logic          start = 1'b0, loop = 1'b0, abort = 1'b0;
  logic [W-1:0]  alu_num1, alu_num2, alu_s, result;
  logic [1:0]    alu_op;
  logic          busy, res_valid, done;
  logic [AW-1:0] res_idx;

  fp_alu_seq #(.WIDTH(W), .DEPTH(DEPTH), .ALU_LAT(3)) dut (
    .clk(clk), .rstn(rstn), .ld_en(ld_en), .ld_addr(ld_addr), .ld_a(ld_a),
    .ld_b(ld_b), .ld_op(ld_op), .count(count), .start(start), .loop(loop),
    .abort(abort), .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op),
    .alu_s(alu_s), .busy(busy), .res_valid(res_valid), .res_idx(res_idx),
    .result(result), .done(done)
  );

  // clock and ALU stand-in
  always #5 clk = ~clk;

  logic [W-1:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= alu_num1 ^ alu_num2;
    p2 <= p1;
    p3 <= p2;
  end
  assign alu_s = p3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  logic [AW-1:0] obs_idx[$];
  logic [W-1:0]  obs_res[$];
  int            obs_cyc[$];
  int            done_n = 0;
  int            done_cyc = 0;
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      obs_idx.push_back(res_idx);
      obs_res.push_back(result);
      obs_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_n   = done_n + 1;
      done_cyc = cyc;
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_a [DEPTH];
  logic [W-1:0] model_b [DEPTH];
  logic [1:0]   model_op[DEPTH];
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_vec(input logic [AW-1:0] a, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [1:0] op, input bit takes);
    ld_en = 1'b1; ld_addr = a; ld_a = va; ld_b = vb; ld_op = op;
    tick();
    ld_en = 1'b0;
    if (takes) begin
      model_a[a] = va; model_b[a] = vb; model_op[a] = op;
    end
  endtask

  task automatic start_run(input logic [CW-1:0] c, input logic lp);
    count = c; loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
    count = 4'd1;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    int d0 = done_n;
    while (done_n == d0 && n < budget) begin tick(); n++; end
    vec_cnt++;
    if (done_n == d0) begin
      err_cnt++;
      $display("FAIL %s_done_timeout: no done within %0d cycles", nm, budget);
    end
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    repeat (3) tick();
    rstn = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
    vec_cnt++; if (res_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %b want 0", done); end
    vec_cnt++; if (alu_num1 !== '0) begin err_cnt++; $display("FAIL rst_num1: got %h want 0", alu_num1); end
    vec_cnt++; if (alu_num2 !== '0) begin err_cnt++; $display("FAIL rst_num2: got %h want 0", alu_num2); end
    vec_cnt++; if (alu_op !== '0) begin err_cnt++; $display("FAIL rst_op: got %h want 0", alu_op); end
    vec_cnt++; if (result !== '0) begin err_cnt++; $display("FAIL rst_result: got %h want 0", result); end
    vec_cnt++; if (res_idx !== '0) begin err_cnt++; $display("FAIL rst_res_idx: got %h want 0", res_idx); end
  endtask

  task automatic test_single();
    int base = obs_idx.size();
    int d0 = done_n;
    int s_cyc;
    ld_vec(3'd0, 32'h3F8E147B, 32'h3F8147AE, OP_ADD, 1'b1);
    s_cyc = cyc;
    start_run(4'd1, 1'b0);
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    vec_cnt++; if (alu_num1 !== 32'h3F8E147B) begin err_cnt++; $display("FAIL single_num1: got %h want 3f8e147b", alu_num1); end
    wait_done("single", 40);
    vec_cnt++;
    if (obs_idx.size() - base !== 1) begin
      err_cnt++; $display("FAIL single_strobes: got %0d want 1", obs_idx.size() - base);
    end else begin
      vec_cnt++; if (obs_res[base] !== 32'h000F53D5) begin err_cnt++; $display("FAIL single_result: got %h want 000f53d5", obs_res[base]); end
      vec_cnt++; if (obs_idx[base] !== 3'd0) begin err_cnt++; $display("FAIL single_idx: got %0d want 0", obs_idx[base]); end
      vec_cnt++; if (obs_cyc[base] - s_cyc !== 6) begin err_cnt++; $display("FAIL single_latency: got %0d want 6", obs_cyc[base] - s_cyc); end
      vec_cnt++; if (done_cyc !== obs_cyc[base] + 1) begin err_cnt++; $display("FAIL single_done_cyc: got %0d want %0d", done_cyc, obs_cyc[base] + 1); end
    end
    vec_cnt++; if (done_n - d0 !== 1) begin err_cnt++; $display("FAIL single_done_cnt: got %0d want 1", done_n - d0); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_full();
    logic [W-1:0] va [8] = '{32'h3F800000, 32'h40000000, 32'hC0490FDB, 32'h00000000,
                             32'h7F800000, 32'h3EAAAAAB, 32'hBF800000, 32'h12345678};
    logic [W-1:0] vb [8] = '{32'h3F800000, 32'h40400000, 32'h40490FDB, 32'h80000000,
                             32'h7FC00000, 32'h3E800000, 32'h3F000000, 32'h87654321};
    logic [1:0] ops [4] = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV};
    int base;
    int d0;
    for (int i = 0; i < 8; i++) ld_vec(AW'(i), va[i], vb[i], ops[i % 4], 1'b1);
    base = obs_idx.size();
    d0 = done_n;
    start_run(4'd8, 1'b0);
    wait_done("full", 100);
    for (int i = 0; i < 8; i++) exp_q.push_back(va[i] ^ vb[i]);
    vec_cnt++;
    if (obs_idx.size() - base !== 8) begin
      err_cnt++; $display("FAIL full_strobes: got %0d want 8", obs_idx.size() - base);
      exp_q.delete();
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [W-1:0] e = exp_q.pop_front();
        vec_cnt++; if (obs_res[base+i] !== e) begin err_cnt++; $display("FAIL full_result[%0d]: got %h want %h", i, obs_res[base+i], e); end
        vec_cnt++; if (obs_idx[base+i] !== AW'(i)) begin err_cnt++; $display("FAIL full_idx[%0d]: got %0d want %0d", i, obs_idx[base+i], i); end
        if (i > 0) begin
          vec_cnt++; if (obs_cyc[base+i] - obs_cyc[base+i-1] !== 5) begin err_cnt++; $display("FAIL full_spacing[%0d]: got %0d want 5", i, obs_cyc[base+i] - obs_cyc[base+i-1]); end
        end
      end
    end
    vec_cnt++; if (done_n - d0 !== 1) begin err_cnt++; $display("FAIL full_done_cnt: got %0d want 1", done_n - d0); end
    vec_cnt++; if (alu_num1 !== va[7] || alu_op !== ops[3]) begin err_cnt++; $display("FAIL full_hold: got %h/%0d want %h/%0d", alu_num1, alu_op, va[7], ops[3]); end
  endtask

  task automatic test_loop();
    int base = obs_idx.size();
    int d0 = done_n;
    int n = 0;
    int tot;
    start_run(4'd3, 1'b1);
    while (obs_idx.size() - base < 10 && n < 200) begin tick(); n++; end
    vec_cnt++; if (obs_idx.size() - base < 10) begin err_cnt++; $display("FAIL loop_timeout: got %0d strobes want 10", obs_idx.size() - base); end
    vec_cnt++; if (done_n !== d0) begin err_cnt++; $display("FAIL loop_early_done: got %0d want 0", done_n - d0); end
    loop = 1'b0;
    wait_done("loop", 60);
    tot = obs_idx.size() - base;
    vec_cnt++; if (tot !== 12) begin err_cnt++; $display("FAIL loop_strobes: got %0d want 12", tot); end
    for (int i = 0; i < tot && i < 12; i++) begin
      logic [AW-1:0] ei = AW'(i % 3);
      vec_cnt++;
      if (obs_idx[base+i] !== ei || obs_res[base+i] !== (model_a[i % 3] ^ model_b[i % 3])) begin
        err_cnt++; $display("FAIL loop_seq[%0d]: got idx %0d res %h want idx %0d res %h", i, obs_idx[base+i], obs_res[base+i], ei, model_a[i % 3] ^ model_b[i % 3]);
      end
    end
    vec_cnt++; if (done_n - d0 !== 1) begin err_cnt++; $display("FAIL loop_done_cnt: got %0d want 1", done_n - d0); end
    if (tot > 0) begin
      vec_cnt++; if (done_cyc !== obs_cyc[base+tot-1] + 1) begin err_cnt++; $display("FAIL loop_done_cyc: got %0d want %0d", done_cyc, obs_cyc[base+tot-1] + 1); end
    end
  endtask

  task automatic test_abort();
    int base = obs_idx.size();
    int d0 = done_n;
    int n = 0;
    start_run(4'd4, 1'b0);
    while (obs_idx.size() == base && n < 50) begin tick(); n++; end
    vec_cnt++; if (obs_idx.size() == base) begin err_cnt++; $display("FAIL abort_first_timeout: got 0 strobes want 1"); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL abort_busy: got %b want 0", busy); end
    repeat (20) tick();
    vec_cnt++; if (obs_idx.size() - base !== 1) begin err_cnt++; $display("FAIL abort_strobes: got %0d want 1", obs_idx.size() - base); end
    vec_cnt++; if (done_n !== d0) begin err_cnt++; $display("FAIL abort_done: got %0d want 0", done_n - d0); end
    vec_cnt++; if (result !== (model_a[0] ^ model_b[0]) || res_idx !== 3'd0) begin err_cnt++; $display("FAIL abort_hold: got %h/%0d want %h/0", result, res_idx, model_a[0] ^ model_b[0]); end
  endtask

  task automatic test_reset_mid();
    int base = obs_idx.size();
    int n = 0;
    start_run(4'd8, 1'b0);
    while (obs_idx.size() - base < 2 && n < 50) begin tick(); n++; end
    tick();
    rstn = 1'b1;
    tick();
    test_reset();
    rstn = 1'b0;
    tick();
    base = obs_idx.size();
    start_run(4'd8, 1'b0);
    wait_done("replay", 100);
    vec_cnt++; if (obs_idx.size() - base !== 8) begin err_cnt++; $display("FAIL replay_strobes: got %0d want 8", obs_idx.size() - base); end
    for (int i = 0; i < 8 && base + i < obs_idx.size(); i++) begin
      vec_cnt++;
      if (obs_res[base+i] !== (model_a[i] ^ model_b[i]) || obs_idx[base+i] !== AW'(i)) begin
        err_cnt++; $display("FAIL replay[%0d]: got %h/%0d want %h/%0d", i, obs_res[base+i], obs_idx[base+i], model_a[i] ^ model_b[i], i);
      end
    end
  endtask

  task automatic test_count_zero();
    int base = obs_idx.size();
    start_run(4'd0, 1'b0);
    tick();
    vec_cnt++; if (done !== 1'b1) begin err_cnt++; $display("FAIL zero_done: got %b want 1", done); end
    repeat (5) tick();
    vec_cnt++; if (obs_idx.size() !== base) begin err_cnt++; $display("FAIL zero_strobes: got %0d want 0", obs_idx.size() - base); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL zero_busy: got %b want 0", busy); end
  endtask

  task automatic test_busy_write();
    int base;
    start_run(4'd2, 1'b0);
    tick();
    ld_vec(3'd0, 32'hDEADBEEF, 32'hCAFEF00D, OP_DIV, 1'b0);
    wait_done("busywr", 40);
    base = obs_idx.size();
    start_run(4'd1, 1'b0);
    wait_done("busywr_chk", 40);
    vec_cnt++;
    if (obs_idx.size() - base !== 1 || obs_res[obs_res.size()-1] !== (model_a[0] ^ model_b[0])) begin
      err_cnt++; $display("FAIL busywr_store: got %0d strobes last %h want 1 strobe %h", obs_idx.size() - base, obs_res[obs_res.size()-1], model_a[0] ^ model_b[0]);
    end
    vec_cnt++; if (alu_op !== model_op[0]) begin err_cnt++; $display("FAIL busywr_op: got %0d want %0d", alu_op, model_op[0]); end
  endtask

  task automatic test_write_start();
    int base = obs_idx.size();
    ld_en = 1'b1; ld_addr = 3'd0; ld_a = 32'h11111111; ld_b = 32'h22222222; ld_op = OP_SUB;
    count = 4'd1; loop = 1'b0; start = 1'b1;
    tick();
    ld_en = 1'b0; start = 1'b0;
    model_a[0] = 32'h11111111; model_b[0] = 32'h22222222; model_op[0] = OP_SUB;
    wait_done("wrstart", 40);
    vec_cnt++;
    if (obs_idx.size() - base !== 1 || obs_res[obs_res.size()-1] !== 32'h33333333) begin
      err_cnt++; $display("FAIL wrstart_result: got %0d strobes last %h want 1 strobe 33333333", obs_idx.size() - base, obs_res[obs_res.size()-1]);
    end
    vec_cnt++; if (alu_op !== OP_SUB) begin err_cnt++; $display("FAIL wrstart_op: got %0d want 1", alu_op); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_full();
    test_loop();
    test_abort();
    test_reset_mid();
    test_count_zero();
    test_busy_write();
    test_write_start();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
